// File: rtl/subpel_interp_block_engine_pkg.sv
// Shared constants for the subpixel block engine: luma tap table, datapath widths, FSM states.
package subpel_pkg;

  localparam int INTER_W = 16;
  localparam int ACC_W   = 28;

  // Phase 0 is a unit tap at position 3 so the same FIR yields the integer sample.
  localparam logic signed [7:0] LUMA_TAPS [4][8] = '{
    '{ 8'sd0,  8'sd0,   8'sd0,  8'sd1,  8'sd0,   8'sd0,  8'sd0,  8'sd0},
    '{-8'sd1,  8'sd4, -8'sd10, 8'sd58, 8'sd17,  -8'sd5,  8'sd1,  8'sd0},
    '{-8'sd1,  8'sd4, -8'sd11, 8'sd40, 8'sd40, -8'sd11,  8'sd4, -8'sd1},
    '{ 8'sd0,  8'sd1,  -8'sd5, 8'sd17, 8'sd58, -8'sd10,  8'sd4, -8'sd1}
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/subpel_interp_block_engine_fir8.sv
// Combinational 8-tap luma FIR: eight signed samples, phase-selected taps, ACC_W sum.
module subpel_fir8
  import subpel_pkg::*;
#(
  parameter int IN_W = 16
) (
  input  logic [1:0]              phase,
  input  logic [7:0][IN_W-1:0]    smp,
  output logic signed [ACC_W-1:0] acc
);

  // Multiply-accumulate over the eight taps chosen by the phase.
  always_comb begin
    logic signed [ACC_W-1:0] s;
    logic signed [ACC_W-1:0] t;
    acc = '0;
    s   = '0;
    t   = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      s   = ACC_W'($signed(smp[k[2:0]]));
      t   = ACC_W'(LUMA_TAPS[phase][k[2:0]]);
      acc = acc + s * t;
    end
  end

endmodule

// File: rtl/subpel_interp_block_engine.sv
// HEVC luma subpel block interpolator: horizontal FIR per row, 8-row window, vertical FIR.
module subpel_interp_block_engine
  import subpel_pkg::*;
#(
  parameter int NUM_PIX  = 8,
  parameter int PIX_W    = 8,
  parameter int MAX_ROWS = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [1:0]                   frac_x,
  input  logic [1:0]                   frac_y,
  input  logic [$clog2(MAX_ROWS):0]    blk_h,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [(NUM_PIX+7)*PIX_W-1:0] in_row,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_PIX*PIX_W-1:0]     out_row,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done
);

  localparam int BH_W   = $clog2(MAX_ROWS) + 1;
  localparam int CNT_W  = $clog2(MAX_ROWS + 8);
  localparam int SHIFT1 = PIX_W - 8;
  localparam int SHIFT3 = 20 - PIX_W;
  localparam logic signed [ACC_W-1:0] ROUND   = ACC_W'(1 << (19 - PIX_W));
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);

  state_e                              state_q, state_d;
  logic [1:0]                          frac_x_q, frac_x_d, frac_y_q, frac_y_d;
  logic [BH_W-1:0]                     blk_h_q, blk_h_d;
  logic [CNT_W-1:0]                    rows_in_q, rows_in_d;
  logic [7:0][NUM_PIX-1:0][INTER_W-1:0] win_q, win_d;
  logic                                s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic                                out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [NUM_PIX*PIX_W-1:0]            out_row_q, out_row_d;
  logic                                done_q, done_d;

  logic                                en, in_hs;
  logic [CNT_W-1:0]                    rows_lim;
  logic [NUM_PIX-1:0][INTER_W-1:0]     h_new;
  logic [NUM_PIX*PIX_W-1:0]            pix_new;

  assign en       = !(out_valid_q && !out_ready);
  assign rows_lim = CNT_W'(blk_h_q) + CNT_W'(7);
  assign in_ready = (state_q != ST_IDLE) && en && (rows_in_q < rows_lim);
  assign in_hs    = in_valid && in_ready;

  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_row   = out_row_q;
  assign done      = done_q;

  for (genvar i = 0; i < NUM_PIX; i++) begin : g_col
    logic [7:0][PIX_W:0]     h_smp;
    logic [7:0][INTER_W-1:0] v_smp;
    logic signed [ACC_W-1:0] h_acc, v_acc;
    logic [INTER_W-1:0]      h_col;
    logic [PIX_W-1:0]        pix_col;

    for (genvar k = 0; k < 8; k++) begin : g_tap
      assign h_smp[k] = {1'b0, in_row[(i+k)*PIX_W +: PIX_W]};
      assign v_smp[k] = win_q[k][i];
    end

    subpel_fir8 #(.IN_W(PIX_W + 1)) u_hfir (.phase(frac_x_q), .smp(h_smp), .acc(h_acc));
    subpel_fir8 #(.IN_W(INTER_W))   u_vfir (.phase(frac_y_q), .smp(v_smp), .acc(v_acc));

    // Scale to the intermediate domain, then round/shift/clip the vertical sum to a pixel.
    always_comb begin
      logic signed [ACC_W-1:0] v;
      logic signed [ACC_W-1:0] r;
      h_col   = (frac_x_q != 2'd0) ? INTER_W'(h_acc >>> SHIFT1) : INTER_W'(h_acc <<< (14 - PIX_W));
      v       = (frac_y_q != 2'd0) ? v_acc : (v_acc <<< 6);
      r       = (v + ROUND) >>> SHIFT3;
      pix_col = '0;
      if (r > PIX_MAX)   pix_col = '1;
      else if (r >= 0)   pix_col = r[PIX_W-1:0];
    end

    assign h_new[i]                     = h_col;
    assign pix_new[i*PIX_W +: PIX_W]    = pix_col;
  end

  // Next-state and datapath: FSM, row counter, window shift, two-stage pipeline under en.
  always_comb begin
    state_d     = state_q;
    frac_x_d    = frac_x_q;
    frac_y_d    = frac_y_q;
    blk_h_d     = blk_h_q;
    rows_in_d   = rows_in_q;
    win_d       = win_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_row_d   = out_row_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: if (start) begin
        state_d   = ST_FILL;
        frac_x_d  = frac_x;
        frac_y_d  = frac_y;
        blk_h_d   = (blk_h == '0) ? BH_W'(1) : blk_h;
        rows_in_d = '0;
      end
      ST_FILL: if (in_hs && rows_in_q == CNT_W'(6)) state_d = ST_RUN;
      ST_RUN: if (out_valid_q && out_ready && out_last_q) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (in_hs) begin
      rows_in_d  = rows_in_q + CNT_W'(1);
      win_d[6:0] = win_q[7:1];
      win_d[7]   = h_new;
    end

    if (en) begin
      s1_valid_d  = in_hs && (rows_in_q >= CNT_W'(7));
      s1_last_d   = in_hs && (rows_in_q == rows_lim - CNT_W'(1));
      out_valid_d = s1_valid_q;
      out_last_d  = s1_last_q;
      if (s1_valid_q) out_row_d = pix_new;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Captured block parameters, counters, window and output pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frac_x_q    <= '0;
      frac_y_q    <= '0;
      blk_h_q     <= '0;
      rows_in_q   <= '0;
      win_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_row_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      frac_x_q    <= frac_x_d;
      frac_y_q    <= frac_y_d;
      blk_h_q     <= blk_h_d;
      rows_in_q   <= rows_in_d;
      win_q       <= win_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_row_q   <= out_row_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_subpel_interp_block_engine.sv
// Self-checking bench: directed blocks with random data against an arithmetic HEVC model.
module tb_subpel_interp_block_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   frac_x, frac_y;
  logic [6:0]   blk_h;
  logic         in_valid, in_ready;
  logic [119:0] in_row;
  logic         out_valid, out_ready;
  logic [63:0]  out_row;
  logic         out_last, busy, done;

  int total = 0;
  int bad   = 0;

  int rows [0:79][0:14];

  int TAPS [4][8] = '{
    '{0, 0, 0, 1, 0, 0, 0, 0},
    '{-1, 4, -10, 58, 17, -5, 1, 0},
    '{-1, 4, -11, 40, 40, -11, 4, -1},
    '{0, 1, -5, 17, 58, -10, 4, -1}
  };

  subpel_interp_block_engine #(.NUM_PIX(8), .PIX_W(8), .MAX_ROWS(64)) dut (
    .clk(clk), .rst(rst), .start(start), .frac_x(frac_x), .frac_y(frac_y),
    .blk_h(blk_h), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Separable HEVC luma interpolation for output row n, 8-bit samples.
  function automatic logic [63:0] exp_row(input int n, input int fx, input int fy);
    int h [8];
    int v, o;
    logic [63:0] res;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < 8; r++) begin
        if (fx == 0) h[r] = rows[n+r][i+3] * 64;
        else begin
          h[r] = 0;
          for (int k = 0; k < 8; k++) h[r] += TAPS[fx][k] * rows[n+r][i+k];
        end
      end
      if (fy == 0) v = h[3] * 64;
      else begin
        v = 0;
        for (int k = 0; k < 8; k++) v += TAPS[fy][k] * h[k];
      end
      o = (v + 2048) >>> 12;
      if (o < 0) o = 0;
      if (o > 255) o = 255;
      res[i*8 +: 8] = 8'(o);
    end
    return res;
  endfunction

  // pat: 0 flat 100, 1 ramp r*8+c, 2 step at column 7, 3 random.
  // mode: 0 free-running, 1 out_ready 1010.. with random in_valid and a stray start.
  task automatic run_block(input int fx, input int fy, input int bh, input int pat,
                           input int mode, input int abort_after);
    int eff, lim, sent, out_cnt, done_cnt, j, first_out, last_out, post;
    bit fin;
    eff = (bh == 0) ? 1 : bh;
    lim = eff + 7;
    for (int r = 0; r < 80; r++)
      for (int c = 0; c < 15; c++)
        case (pat)
          0:       rows[r][c] = 100;
          1:       rows[r][c] = r * 8 + c;
          2:       rows[r][c] = (c >= 7) ? 255 : 0;
          default: rows[r][c] = int'($urandom_range(0, 255));
        endcase
    @(negedge clk);
    frac_x    = 2'(fx);
    frac_y    = 2'(fy);
    blk_h     = 7'(bh);
    start     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    sent = 0; out_cnt = 0; done_cnt = 0; j = 0; first_out = -1; last_out = -1; post = 0;
    fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      j++;
      start = 1'b0;
      if (mode == 1 && j == 5) begin
        start  = 1'b1;
        frac_x = 2'(fx + 1);
        blk_h  = 7'd3;
      end
      out_ready = (mode == 1) ? (j % 2 == 1) : 1'b1;
      in_valid  = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int c = 0; c < 15; c++)
        in_row[c*8 +: 8] = (sent < lim) ? 8'(rows[sent][c]) : 8'($urandom_range(0, 255));
      #1;
      if (done) begin
        done_cnt++;
        check("busy_at_done", {63'd0, busy}, 64'd0);
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        if (out_cnt < eff) begin
          check($sformatf("row%0d", out_cnt), out_row, exp_row(out_cnt, fx, fy));
          check($sformatf("last%0d", out_cnt), {63'd0, out_last}, {63'd0, out_cnt == eff - 1});
        end else
          check("extra_row", 64'(out_cnt), 64'(eff - 1));
        if (out_cnt == 0) first_out = j;
        last_out = j;
        out_cnt++;
        if (abort_after > 0 && out_cnt == abort_after) fin = 1'b1;
      end
      if (done_cnt > 0) post++;
      if (post >= 3 || j >= 3000) fin = 1'b1;
      @(posedge clk);
    end
    in_valid = 1'b0;
    if (abort_after == 0) begin
      check("rows_out", 64'(out_cnt), 64'(eff));
      check("rows_in", 64'(sent), 64'(lim));
      check("done_pulses", 64'(done_cnt), 64'd1);
      if (mode == 0) begin
        check("first_out_cycle", 64'(first_out), 64'd10);
        check("last_out_cycle", 64'(last_out), 64'(eff + 9));
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; frac_x = '0; frac_y = '0; blk_h = '0;
    in_valid = 1'b0; in_row = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_row", out_row, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_out_last", {63'd0, out_last}, 64'd0);
    rst = 1'b0;
    in_valid = 1'b1;
    #1;
    check("idle_in_ready", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b0;

    run_block(1, 2, 4, 0, 0, 0);   // flat field
    run_block(0, 0, 5, 1, 0, 0);   // integer copy of ramp
    run_block(2, 0, 3, 2, 0, 0);   // half-pel horizontal step
    run_block(1, 3, 16, 3, 0, 0);  // quarter 2-D random
    run_block(3, 1, 10, 3, 1, 0);  // backpressure, stray start
    run_block(2, 2, 1, 3, 0, 0);   // single row
    run_block(1, 0, 0, 3, 0, 0);   // blk_h=0 behaves as 1
    run_block(1, 1, 64, 3, 0, 0);  // largest block

    run_block(3, 2, 8, 3, 0, 3);   // abort after three outputs
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_out_row", out_row, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("mid_rst_out_last", {63'd0, out_last}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_block(2, 1, 2, 3, 0, 0);   // clean block after reset

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
